stage_mem: RTL and testbench

MIPS pipeline memory stage; consumes the EX/MEM register outputs of stage_exe (alu result, store data, wbi, M, regaddr, zero, branch/jump controls).
- Resolves branches/jumps toward stage_if.
- Performs loads/stores over a req/ack data-memory port, stalling upstream while an access is outstanding.
- Drives the MEM/WB pipeline register.

---
 rtl/mips_pkg.sv | 18 +
 rtl/mem_port_fsm.sv | 95 +++++++++
 rtl/stage_mem.sv | 98 +++++++++
 tb/tb_stage_mem.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS memory stage and its memory-port controller.
// Holds the port FSM state encoding, write-back control bit positions and
// the default bus timeout.
package mips_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Bit positions inside the 2-bit write-back control field.
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    // Default number of request cycles allowed before an access is abandoned.
    localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/mem_port_fsm.sv
// Data-memory port controller: launches one request per memory op and waits for ack.
// Latency: request registered on the arrival edge; completes on the ack-cycle edge.
// Backpressure: reports busy-wait so the stage can freeze upstream; aborts after TIMEOUT cycles.
module mem_port_fsm
    import mips_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_m,
    input  logic        i_load,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_ack,
    output logic        o_idle,
    output logic        o_start,
    output logic        o_misalign,
    output logic        o_ack_done,
    output logic        o_abort,
    output logic        o_busy_wait,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_bus_err
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            w_access;
    logic            w_aligned;
    logic            w_tmo_hit;

    assign w_access    = (r_state == ACCESS);
    assign w_aligned   = (i_addr[1:0] == 2'b00);
    assign w_tmo_hit   = w_access && (r_cnt == CW'(TIMEOUT - 1));

    assign o_idle      = ~w_access;
    assign o_start     = ~w_access & i_m & w_aligned;
    assign o_misalign  = ~w_access & i_m & ~w_aligned;
    assign o_ack_done  = w_access & i_ack;
    // A late ack in the timeout cycle still completes the access.
    assign o_abort     = w_tmo_hit & ~i_ack;
    assign o_busy_wait = w_access & ~i_ack & ~w_tmo_hit;

    // Port state, timeout counter, request registers and sticky error flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_bus_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (o_start) begin
                        r_state     <= ACCESS;
                        o_mem_req   <= 1'b1;
                        o_mem_we    <= ~i_load;
                        o_mem_addr  <= i_addr;
                        o_mem_wdata <= i_wdata;
                    end else if (o_misalign) begin
                        o_bus_err <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (i_ack) begin
                        r_state   <= IDLE;
                        r_cnt     <= '0;
                        o_mem_req <= 1'b0;
                    end else if (w_tmo_hit) begin
                        r_state   <= IDLE;
                        r_cnt     <= '0;
                        o_mem_req <= 1'b0;
                        o_bus_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    o_mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/stage_mem.sv
// MIPS memory stage: branch resolution, data-memory access and MEM/WB register.
// Latency: 1 cycle for ALU ops; memory ops take 2+ cycles (request edge, then ack edge).
// Backpressure: stall_o freezes upstream while a request is pending; redirect fires once on advance.
module stage_mem
    import mips_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] alu_out,
    input  logic [31:0] data_b,
    input  logic [1:0]  wbi,
    input  logic        M,
    input  logic [4:0]  regaddr,
    input  logic        zero,
    input  logic        is_jump,
    input  logic        branch_eq,
    input  logic        branch_inc,
    input  logic [31:0] jump_address,
    output logic        pc_src_o,
    output logic [31:0] pc_target_o,
    output logic        stall_o,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        bus_err_o,
    output logic [1:0]  wbi_o,
    output logic [4:0]  regaddr_o,
    output logic [31:0] alu_out_o,
    output logic [31:0] mem_data_o
);

    logic w_idle;
    logic w_start;
    logic w_misalign;
    logic w_ack_done;
    logic w_abort;
    logic w_busy_wait;
    logic w_take;

    mem_port_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_port (
        .clock       (clock),
        .reset       (reset),
        .i_m         (M),
        .i_load      (wbi[WB_MEMTOREG]),
        .i_addr      (alu_out),
        .i_wdata     (data_b),
        .i_ack       (mem_ack),
        .o_idle      (w_idle),
        .o_start     (w_start),
        .o_misalign  (w_misalign),
        .o_ack_done  (w_ack_done),
        .o_abort     (w_abort),
        .o_busy_wait (w_busy_wait),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_bus_err   (bus_err_o)
    );

    // Stall covers the launch cycle and every cycle still waiting on the bus.
    assign stall_o     = w_start | w_busy_wait;

    assign w_take      = is_jump | (branch_eq & zero) | (branch_inc & ~zero);
    // Gating with stall makes the redirect a single pulse on the advancing cycle.
    assign pc_src_o    = w_take & ~stall_o;
    assign pc_target_o = jump_address;

    // MEM/WB register: load on completion, bubble on launch/error, hold while waiting.
    always_ff @(posedge clock) begin
        if (reset) begin
            wbi_o      <= '0;
            regaddr_o  <= '0;
            alu_out_o  <= '0;
            mem_data_o <= '0;
        end else if (w_ack_done) begin
            wbi_o      <= wbi;
            regaddr_o  <= regaddr;
            alu_out_o  <= alu_out;
            mem_data_o <= wbi[WB_MEMTOREG] ? mem_rdata : 32'h0;
        end else if (w_start | w_misalign | w_abort) begin
            wbi_o <= '0;
        end else if (w_idle & ~M) begin
            wbi_o      <= wbi;
            regaddr_o  <= regaddr;
            alu_out_o  <= alu_out;
            mem_data_o <= 32'h0;
        end
    end

endmodule

// File: tb/tb_stage_mem.sv
// Scoreboard bench for stage_mem: directed instructions, queued expectations,
// and independent monitors for the MEM/WB register and memory requests.
module tb_stage_mem;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] alu_out = '0, data_b = '0, jump_address = '0, mem_rdata = '0;
    logic [1:0]  wbi = '0;
    logic        M = 1'b0, zero = 1'b0, is_jump = 1'b0, branch_eq = 1'b0, branch_inc = 1'b0;
    logic [4:0]  regaddr = '0;
    logic        auto_ack = 1'b0, force_ack = 1'b0, mem_ack;
    logic        pc_src_o, stall_o, mem_req, mem_we, bus_err_o;
    logic [31:0] pc_target_o, mem_addr, mem_wdata, alu_out_o, mem_data_o;
    logic [1:0]  wbi_o;
    logic [4:0]  regaddr_o;

    assign mem_ack = auto_ack | force_ack;

    stage_mem #(.TIMEOUT(16)) dut (
        .clock(clock), .reset(reset), .alu_out(alu_out), .data_b(data_b), .wbi(wbi),
        .M(M), .regaddr(regaddr), .zero(zero), .is_jump(is_jump), .branch_eq(branch_eq),
        .branch_inc(branch_inc), .jump_address(jump_address), .pc_src_o(pc_src_o),
        .pc_target_o(pc_target_o), .stall_o(stall_o), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .bus_err_o(bus_err_o), .wbi_o(wbi_o), .regaddr_o(regaddr_o), .alu_out_o(alu_out_o),
        .mem_data_o(mem_data_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        bub;
        logic [1:0]  wbi;
        logic [4:0]  ra;
        logic [31:0] alu;
        logic [31:0] md;
    } wb_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
    } req_t;

    wb_t  wb_q[$];
    req_t req_q[$];
    int   checks = 0;
    int   errors = 0;
    logic tb_vld = 1'b0;
    logic ack_en = 1'b0;
    int   ack_at = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Memory model: acks on the ack_at-th consecutive request cycle.
    initial begin
        int rc;
        rc = 0;
        forever begin
            @(posedge clock);
            #1;
            if (mem_req) rc++;
            else rc = 0;
            auto_ack = ack_en && (rc == ack_at);
        end
    end

    // MEM/WB monitor: the edge after an advancing cycle carries one result.
    initial begin
        logic prev_adv;
        wb_t  e;
        prev_adv = 1'b0;
        forever begin
            @(negedge clock);
            if (prev_adv) begin
                if (wb_q.size() == 0) begin
                    chk("wb_unexpected", 32'(wbi_o), 32'hFFFF_FFFF);
                end else begin
                    e = wb_q.pop_front();
                    chk("wb_wbi", 32'(wbi_o), 32'(e.wbi));
                    if (!e.bub) begin
                        chk("wb_regaddr", 32'(regaddr_o), 32'(e.ra));
                        chk("wb_alu", alu_out_o, e.alu);
                        chk("wb_mdata", mem_data_o, e.md);
                    end
                end
            end
            prev_adv = tb_vld && !stall_o && !reset;
        end
    end

    // Request monitor: every rising mem_req must match the next queued request.
    initial begin
        logic prev_req;
        req_t r;
        prev_req = 1'b0;
        forever begin
            @(negedge clock);
            if (mem_req && !prev_req) begin
                if (req_q.size() == 0) begin
                    chk("req_unexpected", mem_addr, 32'hFFFF_FFFF);
                end else begin
                    r = req_q.pop_front();
                    chk("req_we", 32'(mem_we), 32'(r.we));
                    chk("req_addr", mem_addr, r.addr);
                    chk("req_wdata", mem_wdata, r.wd);
                end
            end
            prev_req = mem_req;
        end
    end

    task automatic clear_inputs();
        M = 0; wbi = '0; alu_out = '0; data_b = '0; regaddr = '0;
        zero = 0; is_jump = 0; branch_eq = 0; branch_inc = 0; jump_address = '0;
    endtask

    // Present one instruction and hold it until the stage advances.
    task automatic issue(input logic m, input logic [1:0] w, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] ra, input logic z,
                         input logic beq, input logic bne, input logic [31:0] tgt,
                         output int stalls, output int reqs, output int pcs,
                         output int pc_bad, output logic [31:0] last_tgt);
        int n;
        stalls = 0; reqs = 0; pcs = 0; pc_bad = 0; last_tgt = '0;
        @(posedge clock);
        #1;
        M = m; wbi = w; alu_out = a; data_b = d; regaddr = ra; zero = z;
        branch_eq = beq; branch_inc = bne; jump_address = tgt; tb_vld = 1'b1;
        for (n = 0; n < 64; n++) begin
            @(negedge clock);
            if (pc_src_o) pcs++;
            if (pc_src_o && stall_o) pc_bad++;
            if (mem_req) reqs++;
            last_tgt = pc_target_o;
            if (!stall_o) break;
            stalls++;
        end
        if (n >= 64) begin
            checks++;
            errors++;
            $display("FAIL issue_bound stall still high after %0d cycles, required low", n);
        end
        @(posedge clock);
        #1;
        clear_inputs();
        tb_vld = 1'b0;
    endtask

    initial begin
        int st, rq, pc, pb;
        logic [31:0] tg;

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_bus_err", 32'(bus_err_o), 0);
        chk("rst_wbi_o", 32'(wbi_o), 0);
        chk("rst_alu_o", alu_out_o, 0);
        @(posedge clock);
        #1 reset = 1'b0;

        // ALU op
        wb_q.push_back('{1'b0, 2'b10, 5'd5, 32'h1234, 32'h0});
        issue(0, 2'b10, 32'h1234, 32'h0, 5'd5, 0, 0, 0, 32'h0, st, rq, pc, pb, tg);
        chk("alu_stalls", st, 0);
        chk("alu_reqs", rq, 0);

        // Load, ack on the third request cycle
        ack_en = 1; ack_at = 3; mem_rdata = 32'hDEADBEEF;
        req_q.push_back('{1'b0, 32'h100, 32'h0000_0BAD});
        wb_q.push_back('{1'b0, 2'b11, 5'd7, 32'h100, 32'hDEADBEEF});
        issue(1, 2'b11, 32'h100, 32'h0000_0BAD, 5'd7, 0, 0, 0, 32'h0, st, rq, pc, pb, tg);
        chk("load_stalls", st, 3);
        chk("load_reqs", rq, 3);

        // Store, ack in the first request cycle
        ack_at = 1; mem_rdata = 32'h5555_5555;
        req_q.push_back('{1'b1, 32'h40, 32'hA5A5A5A5});
        wb_q.push_back('{1'b0, 2'b00, 5'd3, 32'h40, 32'h0});
        issue(1, 2'b00, 32'h40, 32'hA5A5A5A5, 5'd3, 0, 0, 0, 32'h0, st, rq, pc, pb, tg);
        chk("store_stalls", st, 1);
        chk("store_reqs", rq, 1);

        // beq taken while a load is stalling
        ack_at = 2; mem_rdata = 32'h11223344;
        req_q.push_back('{1'b0, 32'h200, 32'h0});
        wb_q.push_back('{1'b0, 2'b11, 5'd8, 32'h200, 32'h11223344});
        issue(1, 2'b11, 32'h200, 32'h0, 5'd8, 1, 1, 0, 32'h0000_8000, st, rq, pc, pb, tg);
        chk("beq_pulses", pc, 1);
        chk("beq_during_stall", pb, 0);
        chk("beq_target", tg, 32'h0000_8000);
        chk("beq_stalls", st, 2);

        // bne with zero set: not taken
        wb_q.push_back('{1'b0, 2'b10, 5'd9, 32'h55, 32'h0});
        issue(0, 2'b10, 32'h55, 32'h0, 5'd9, 1, 0, 1, 32'h0000_9000, st, rq, pc, pb, tg);
        chk("bne_z1_pc", pc, 0);

        // bne with zero clear: taken in one cycle
        wb_q.push_back('{1'b0, 2'b10, 5'd10, 32'h66, 32'h0});
        issue(0, 2'b10, 32'h66, 32'h0, 5'd10, 0, 0, 1, 32'h0000_A000, st, rq, pc, pb, tg);
        chk("bne_z0_pc", pc, 1);
        chk("bne_z0_target", tg, 32'h0000_A000);

        // Misaligned address
        wb_q.push_back('{1'b1, 2'b00, 5'd0, 32'h0, 32'h0});
        issue(1, 2'b11, 32'h102, 32'h0, 5'd11, 0, 0, 0, 32'h0, st, rq, pc, pb, tg);
        chk("mis_stalls", st, 0);
        chk("mis_reqs", rq, 0);
        @(negedge clock);
        chk("mis_bus_err", 32'(bus_err_o), 1);

        // Reset two cycles into an access, then a stray ack
        ack_en = 0;
        req_q.push_back('{1'b0, 32'h300, 32'h0});
        @(posedge clock);
        #1;
        M = 1; wbi = 2'b11; alu_out = 32'h300; regaddr = 5'd4;
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        clear_inputs();
        @(negedge clock);
        chk("mid_rst_req", 32'(mem_req), 0);
        chk("mid_rst_bus_err", 32'(bus_err_o), 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_wbi", 32'(wbi_o), 0);
        chk("mid_rst_ra", 32'(regaddr_o), 0);
        chk("mid_rst_stall", 32'(stall_o), 0);
        @(posedge clock);
        #2 force_ack = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        @(posedge clock);
        #2 force_ack = 1'b0;
        @(negedge clock);
        chk("late_ack_wbi", 32'(wbi_o), 0);
        chk("late_ack_mdata", mem_data_o, 0);
        chk("late_ack_req", 32'(mem_req), 0);

        // Timeout: no ack ever arrives
        req_q.push_back('{1'b1, 32'h80, 32'h77});
        wb_q.push_back('{1'b1, 2'b00, 5'd0, 32'h0, 32'h0});
        issue(1, 2'b00, 32'h80, 32'h77, 5'd12, 0, 0, 0, 32'h0, st, rq, pc, pb, tg);
        chk("tmo_reqs", rq, 16);
        chk("tmo_stalls", st, 16);
        repeat (3) @(negedge clock);
        chk("tmo_bus_err_sticky", 32'(bus_err_o), 1);
        chk("tmo_req_low", 32'(mem_req), 0);

        repeat (2) @(negedge clock);
        chk("wb_queue_drained", wb_q.size(), 0);
        chk("req_queue_drained", req_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
